seven_seg_scan_ctrl: RTL and testbench

SEVEN_SEG_SCAN_CTRL -- requirements
Module: seven_seg_scan_ctrl

---
 rtl/seven_seg_scan_ctrl.sv | 134 +++++++++++++
 tb/tb_seven_seg_scan_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_scan_ctrl.sv
// seven_seg_scan_ctrl
//   Time-multiplexed 7-segment display scanner with hex decode, leading-zero
//   blanking, per-digit decimal point, PWM brightness and tear-free updates.
//
// Ports
//   i_clk       sole clock (rising edge)
//   i_rst       asynchronous active-high reset
//   i_data      4*N_DIGITS hex nibbles, digit 0 = i_data[3:0] (rightmost)
//   i_load      single-cycle strobe capturing i_data / i_dp into the pending register
//   i_dp        per-digit decimal-point request
//   i_blank_lz  enable leading-zero suppression
//   i_bright    PWM duty code, duty = (i_bright+1)/2^BRIGHT_W, sampled live
//   o_an        digit anode enables (one-hot when lit)
//   o_seg       segments {g,f,e,d,c,b,a}
//   o_dp        decimal-point segment
//   o_frame     one-cycle pulse after each frame wrap
//   o_an/o_seg/o_dp are active-low when ACTIVE_LOW=1.
module seven_seg_scan_ctrl #(
    parameter int N_DIGITS   = 4,
    parameter int CLK_DIV    = 100000,
    parameter int BRIGHT_W   = 4,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [4*N_DIGITS-1:0]   i_data,
    input  logic                    i_load,
    input  logic [N_DIGITS-1:0]     i_dp,
    input  logic                    i_blank_lz,
    input  logic [BRIGHT_W-1:0]     i_bright,
    output logic [N_DIGITS-1:0]     o_an,
    output logic [6:0]              o_seg,
    output logic                    o_dp,
    output logic                    o_frame
);

    localparam int   PW  = (CLK_DIV  > 1) ? $clog2(CLK_DIV)  : 1;
    localparam int   IW  = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam logic POL = (ACTIVE_LOW != 0);

    logic [PW-1:0]           presc;
    logic [IW-1:0]           idx;
    logic [BRIGHT_W-1:0]     pwm_cnt;
    logic [4*N_DIGITS-1:0]   pend_data, disp_data;
    logic [N_DIGITS-1:0]     pend_dp, disp_dp;

    logic                    tick, wrap;
    logic [N_DIGITS-1:0]     blank;
    logic                    upper_zero;
    logic [3:0]              nib;
    logic                    sel_blank;
    logic [N_DIGITS-1:0]     an_hi;
    logic [6:0]              seg_hi;
    logic                    dp_hi;

    // Active-high {g,f,e,d,c,b,a} pattern for a hex nibble.
    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 7'b0111111;
            4'h1: hex7 = 7'b0000110;
            4'h2: hex7 = 7'b1011011;
            4'h3: hex7 = 7'b1001111;
            4'h4: hex7 = 7'b1100110;
            4'h5: hex7 = 7'b1101101;
            4'h6: hex7 = 7'b1111101;
            4'h7: hex7 = 7'b0000111;
            4'h8: hex7 = 7'b1111111;
            4'h9: hex7 = 7'b1101111;
            4'hA: hex7 = 7'b1110111;
            4'hB: hex7 = 7'b1111100;
            4'hC: hex7 = 7'b0111001;
            4'hD: hex7 = 7'b1011110;
            4'hE: hex7 = 7'b1111001;
            default: hex7 = 7'b1110001;
        endcase
    endfunction

    assign tick = (presc == PW'(CLK_DIV - 1));
    assign wrap = tick && (idx == IW'(N_DIGITS - 1));

    always_comb begin
        // Walk from the most significant digit down; a digit is a leading
        // zero when it and everything above it is zero. Digit 0 always shows.
        upper_zero = 1'b1;
        blank      = '0;
        for (int k = N_DIGITS - 1; k >= 0; k--) begin
            upper_zero = upper_zero && (disp_data[4*k +: 4] == 4'd0);
            blank[k]   = (k != 0) && i_blank_lz && upper_zero;
        end
        nib       = disp_data[4*idx +: 4];
        sel_blank = blank[idx];
        an_hi     = (!sel_blank && (pwm_cnt <= i_bright)) ? (N_DIGITS'(1) << idx) : '0;
        seg_hi    = sel_blank ? 7'd0 : hex7(nib);
        dp_hi     = !sel_blank && disp_dp[idx];
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            presc     <= '0;
            idx       <= '0;
            pwm_cnt   <= '0;
            pend_data <= '0;
            pend_dp   <= '0;
            disp_data <= '0;
            disp_dp   <= '0;
            o_an      <= {N_DIGITS{POL}};
            o_seg     <= {7{POL}};
            o_dp      <= POL;
            o_frame   <= 1'b0;
        end else begin
            pwm_cnt <= pwm_cnt + 1'b1;
            presc   <= tick ? '0 : presc + 1'b1;
            if (tick)
                idx <= wrap ? '0 : idx + 1'b1;

            if (i_load) begin
                pend_data <= i_data;
                pend_dp   <= i_dp;
            end
            // Display only changes at the frame wrap; a load on the wrap edge
            // itself bypasses the pending register so it is not a frame late.
            if (wrap) begin
                disp_data <= i_load ? i_data : pend_data;
                disp_dp   <= i_load ? i_dp   : pend_dp;
            end

            o_frame <= wrap;
            o_an    <= an_hi  ^ {N_DIGITS{POL}};
            o_seg   <= seg_hi ^ {7{POL}};
            o_dp    <= dp_hi  ^ POL;
        end
    end

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
module tb_seven_seg_scan_ctrl;

    localparam int N  = 4;
    localparam int CD = 4;
    localparam int FR = N * CD;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] data = '0;
    logic        load = 1'b0;
    logic [3:0]  dp = '0;
    logic        blank_lz = 1'b0;
    logic [3:0]  bright = 4'd15;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp_o;
    logic        frame;

    int checks = 0;
    int failures = 0;

    seven_seg_scan_ctrl #(.N_DIGITS(N), .CLK_DIV(CD), .BRIGHT_W(4), .ACTIVE_LOW(1)) dut (
        .i_clk(clk), .i_rst(rst), .i_data(data), .i_load(load), .i_dp(dp),
        .i_blank_lz(blank_lz), .i_bright(bright),
        .o_an(an), .o_seg(seg), .o_dp(dp_o), .o_frame(frame)
    );

    always #5 clk = ~clk;

    // Active-high glyphs, indexed by nibble value.
    logic [6:0] glyph [16] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
                               7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
                               7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
                               7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001};

    // ---------------- behavioural model ----------------
    // st = clock edges since reset release. Which digit is scanned, the PWM
    // phase and frame position all follow from st by plain division.
    int          st;
    logic [15:0] m_pend, m_disp;
    logic [3:0]  m_pdp, m_ddp;
    logic [3:0]  e_an;
    logic [6:0]  e_seg;
    logic        e_dp, e_frame;

    function automatic logic [11:0] model_out(input int s, input logic [15:0] d,
                                              input logic [3:0] ddp, input logic lz,
                                              input logic [3:0] br);
        int         dig;
        logic       bl;
        logic [3:0] a;
        logic [6:0] sg;
        logic       p;
        dig = (s / CD) % N;
        bl  = lz && (dig >= 1) && ((d >> (4 * dig)) == 16'd0);
        a   = (!bl && ((s % 16) <= int'(br))) ? ~(4'b0001 << dig) : 4'b1111;
        sg  = bl ? 7'b1111111 : ~glyph[d[4*dig +: 4]];
        p   = !(!bl && ddp[dig]);
        return {a, sg, p};
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            st      <= 0;
            m_pend  <= '0;
            m_disp  <= '0;
            m_pdp   <= '0;
            m_ddp   <= '0;
            e_an    <= 4'b1111;
            e_seg   <= 7'b1111111;
            e_dp    <= 1'b1;
            e_frame <= 1'b0;
        end else begin
            {e_an, e_seg, e_dp} <= model_out(st, m_disp, m_ddp, blank_lz, bright);
            e_frame <= ((st % FR) == FR - 1);
            if ((st % FR) == FR - 1) begin
                m_disp <= load ? data : m_pend;
                m_ddp  <= load ? dp   : m_pdp;
            end
            if (load) begin
                m_pend <= data;
                m_pdp  <= dp;
            end
            st <= st + 1;
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            checks++;
            if ({an, seg, dp_o, frame} !== {e_an, e_seg, e_dp, e_frame}) begin
                failures++;
                $display("FAIL model t=%0t an=%b seg=%b dp=%b frame=%b required an=%b seg=%b dp=%b frame=%b",
                         $time, an, seg, dp_o, frame, e_an, e_seg, e_dp, e_frame);
            end
        end
    end

    // ---------------- directed checks ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t actual=%0h required=%0h", name, $time, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_frame();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame && n < 64);
        chk("frame_seen", {31'd0, frame}, 32'd1);
    endtask

    logic [3:0] an_lit   [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    logic [6:0] seg_4321 [4] = '{7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001};
    logic [6:0] seg_abcd [4] = '{7'b0100001, 7'b1000110, 7'b0000011, 7'b0001000};

    initial begin
        int cnt, cnt2, bad;
        bool_done: begin end
        step(3);
        rst = 1'b0;

        // Load mid-frame, then reset asynchronously: outputs go idle at once
        // and the pending load is lost.
        step(5);
        load = 1'b1; data = 16'h1234; dp = 4'hF;
        step(1);
        load = 1'b0;
        step(2);
        #2 rst = 1'b1;
        #1;
        chk("rst_an", an, 4'b1111);
        chk("rst_seg", seg, 7'b1111111);
        chk("rst_dp", dp_o, 1'b1);
        chk("rst_frame", frame, 1'b0);
        step(2);
        rst = 1'b0; data = '0; dp = '0;

        // Tear-free update: FFFF loaded mid-frame while 0000 shows.
        wait_frame();
        step(6);
        load = 1'b1; data = 16'hFFFF;
        step(1);
        load = 1'b0; data = '0;
        for (int i = 0; i < 40; i++) begin
            step(1);
            chk("tear_old", seg, 7'b1000000);
            if (frame) break;
        end
        chk("tear_wrap", {31'd0, frame}, 32'd1);
        for (int i = 0; i < 16; i++) begin
            step(1);
            chk("tear_new", seg, 7'b0001110);
        end

        // Scan order with 4321.
        load = 1'b1; data = 16'h4321;
        step(1);
        load = 1'b0; data = '0;
        wait_frame();
        for (int i = 0; i < 16; i++) begin
            step(1);
            chk("scan_an", an, an_lit[i / 4]);
            chk("scan_seg", seg, seg_4321[i / 4]);
        end
        cnt = 0;
        for (int i = 0; i < 48; i++) begin
            step(1);
            if (frame) cnt++;
        end
        chk("frame_cnt", cnt, 3);

        // Load on the wrap tick itself.
        wait_frame();
        step(15);
        load = 1'b1; data = 16'hABCD; dp = 4'b0001;
        step(1);
        load = 1'b0; data = '0; dp = '0;
        for (int i = 0; i < 16; i++) begin
            step(1);
            chk("wrap_seg", seg, seg_abcd[i / 4]);
            chk("wrap_dp", dp_o, (i / 4 == 0) ? 1'b0 : 1'b1);
        end

        // Brightness.
        bright = 4'd3;
        step(2);
        cnt = 0;
        for (int i = 0; i < 16; i++) begin
            step(1);
            if (an != 4'b1111) cnt++;
        end
        chk("bright3_lit", cnt, 4);
        bright = 4'd15;
        step(2);
        cnt = 0;
        for (int i = 0; i < 16; i++) begin
            step(1);
            if (an != 4'b1111) cnt++;
        end
        chk("bright15_lit", cnt, 16);

        // Leading-zero suppression with 0050, then 0000.
        blank_lz = 1'b1;
        load = 1'b1; data = 16'h0050;
        step(1);
        load = 1'b0; data = '0;
        wait_frame();
        cnt = 0; cnt2 = 0; bad = 0;
        for (int i = 0; i < 16; i++) begin
            step(1);
            if (!an[3] || !an[2]) bad++;
            if (an == 4'b1101) begin cnt++;  chk("lz_d1_seg", seg, 7'b0010010); end
            if (an == 4'b1110) begin cnt2++; chk("lz_d0_seg", seg, 7'b1000000); end
        end
        chk("lz_upper_lit", bad, 0);
        chk("lz_d1_cycles", cnt, 4);
        chk("lz_d0_cycles", cnt2, 4);
        load = 1'b1; data = 16'h0000;
        step(1);
        load = 1'b0;
        wait_frame();
        cnt = 0; bad = 0;
        for (int i = 0; i < 16; i++) begin
            step(1);
            if (an == 4'b1110) cnt++;
            else if (an != 4'b1111) bad++;
        end
        chk("zero_d0_cycles", cnt, 4);
        chk("zero_other_lit", bad, 0);

        step(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
